instruction_fetch_unit: RTL

Fetch stage of the pipelined MIPS core: owns the program counter, issues instruction-memory requests over a ready handshake, and produces the PC+4 / instruction / valid payload that the IF/ID pipeline register samples every cycle. It absorbs memory wait states with bubbles, holds its outputs under a hazard stall, and squashes wrong-path fetches on a branch or jump redirect from decode.

---
 rtl/instruction_fetch_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the pipelined MIPS core.
// Owns the program counter, issues instruction-memory requests over a ready
// handshake and produces the PC+4 / instruction / valid payload for IF/ID.
// Memory wait states become bubbles, a hazard stall freezes the payload, and
// a redirect from decode flushes the payload and squashes wrong-path fetches.
`timescale 1ns/1ps

module instruction_fetch_unit #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   PC_RESET = 32'h0040_0000,
    parameter logic [N-1:0]   NOP      = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] OUT_PC_Conter_Plus_4,
    output logic [N-1:0] OUT_Instruction_Wire,
    output logic         OUT_Valid
);

    // FETCH: request outstanding; HOLD: one instruction parked in the buffer
    // while stalled; DROP: in-flight fetch belongs to the wrong path.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [N-1:0] FOUR = N'(4);

    state_t       state, state_d;
    logic [N-1:0] addr, addr_d;
    logic [N-1:0] buffer, buffer_d;
    logic [N-1:0] target, target_d;
    logic [N-1:0] pc4_d;
    logic [N-1:0] instr_d;
    logic         valid_d;

    logic [N-1:0] addr_plus4;
    logic [N-1:0] redirect_aligned;

    assign addr_plus4       = addr + FOUR;
    assign redirect_aligned = {redirect_pc[N-1:2], 2'b00};

    // The request is a pure decode of the state; the address is the PC register.
    assign imem_req  = (state != HOLD);
    assign imem_addr = addr;

    // State, PC, buffer, saved target and payload registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= FETCH;
            addr                 <= PC_RESET;
            buffer               <= '0;
            target               <= '0;
            OUT_PC_Conter_Plus_4 <= '0;
            OUT_Instruction_Wire <= NOP;
            OUT_Valid            <= 1'b0;
        end else begin
            state                <= state_d;
            addr                 <= addr_d;
            buffer               <= buffer_d;
            target               <= target_d;
            OUT_PC_Conter_Plus_4 <= pc4_d;
            OUT_Instruction_Wire <= instr_d;
            OUT_Valid            <= valid_d;
        end
    end

    // Next-state, next-PC and next-payload decode; priority redirect > stall > normal.
    always_comb begin
        state_d  = state;
        addr_d   = addr;
        buffer_d = buffer;
        target_d = target;
        pc4_d    = OUT_PC_Conter_Plus_4;
        instr_d  = OUT_Instruction_Wire;
        valid_d  = OUT_Valid;

        if (redirect_valid) begin
            pc4_d   = '0;
            instr_d = NOP;
            valid_d = 1'b0;
            unique case (state)
                FETCH: begin
                    if (imem_ready) begin
                        addr_d = redirect_aligned;
                    end else begin
                        // Request already presented: keep imem_addr stable and
                        // swallow the late response before using the target.
                        target_d = redirect_aligned;
                        state_d  = DROP;
                    end
                end
                HOLD: begin
                    addr_d  = redirect_aligned;
                    state_d = FETCH;
                end
                DROP: begin
                    if (imem_ready) begin
                        // The wrong-path response lands this cycle, so the
                        // newest target can be fetched straight away.
                        addr_d  = redirect_aligned;
                        state_d = FETCH;
                    end else begin
                        target_d = redirect_aligned;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (stall) begin
                        if (imem_ready) begin
                            buffer_d = imem_rdata;
                            state_d  = HOLD;
                        end
                    end else if (imem_ready) begin
                        pc4_d   = addr_plus4;
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        addr_d  = addr_plus4;
                    end else begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc4_d   = addr_plus4;
                        instr_d = buffer;
                        valid_d = 1'b1;
                        addr_d  = addr_plus4;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (!stall) begin
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        addr_d  = target;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

endmodule
